twiddle_sequencer: RTL and testbench

TWIDDLE_SEQUENCER -- requirements
Module: twiddle_sequencer

---
 rtl/fft_pkg.sv | 25 ++
 rtl/bfly_addr_gen.sv | 32 +++
 rtl/twiddle_sequencer.sv | 142 ++++++++++++++
 tb/tb_twiddle_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address sequencing blocks: FSM encoding,
// default transform size and parameter legality helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int N_DEFAULT     = 16;
  localparam int LOG2N_DEFAULT = $clog2(N_DEFAULT);

  function automatic bit rom_lat_legal(input int lat);
    return (lat == 0) || (lat == 1);
  endfunction

  // Stage port is wide enough to carry LOG2N itself, so an out-of-range
  // request can actually be presented and rejected.
  function automatic int stage_width(input int log2n);
    return (log2n < 2) ? 1 : $clog2(log2n + 1);
  endfunction

endpackage

// File: rtl/bfly_addr_gen.sv
// Combinational DIF butterfly address generator: butterfly index j and stage
// map to the two sample addresses and the twiddle ROM address.
module bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int LOG2N = $clog2(N),
  parameter int SW    = stage_width(LOG2N)
) (
  input  logic [LOG2N-2:0] j_i,
  input  logic [SW-1:0]    stage_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] coef_addr_o
);

  localparam logic [LOG2N-1:0] HALF0 = LOG2N'(N / 2);

  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] j_ext;

  assign half  = HALF0 >> stage_i;
  assign mask  = half - 1'b1;
  assign j_ext = {1'b0, j_i};

  // grp*2*half equals the group bits of j moved up one place; pos stays put.
  assign addr_a_o    = ((j_ext & ~mask) << 1) | (j_ext & mask);
  assign addr_b_o    = addr_a_o | half;
  assign coef_addr_o = j_i << stage_i;

endmodule

// File: rtl/twiddle_sequencer.sv
// Per-stage FFT butterfly sequencer: steps j through N/2 butterflies, drives the
// twiddle ROM address and delays the sample addresses to line up with ROM data.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int ROM_LAT = 1,
  localparam int LOG2N   = $clog2(N),
  localparam int SW      = stage_width(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW-1:0]    stage,
  input  logic             inverse,
  input  logic             hold,
  output logic [LOG2N-2:0] coef_addr,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic             o_we,
  output logic             conj,
  output logic             busy,
  output logic             dv,
  output logic             err
);

  if (!rom_lat_legal(ROM_LAT) || (N < 4) || ((1 << LOG2N) != N)) begin : g_bad_param
    $error("twiddle_sequencer: N must be a power of two >= 4 and ROM_LAT 0 or 1");
  end

  localparam logic [LOG2N-2:0] J_LAST    = '1;
  localparam logic [SW-1:0]    STAGE_LIM = SW'(LOG2N);

  state_e           state_q;
  logic [LOG2N-2:0] j_q;
  logic [SW-1:0]    stage_q;
  logic             conj_q;
  logic             busy_q;
  logic             dv_q;
  logic             err_q;

  logic             issue;
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [LOG2N-2:0] gen_coef;
  logic [LOG2N-1:0] addr_a_d;
  logic [LOG2N-1:0] addr_b_d;

  bfly_addr_gen #(.N(N), .LOG2N(LOG2N), .SW(SW)) u_addr (
    .j_i        (j_q),
    .stage_i    (stage_q),
    .addr_a_o   (gen_a),
    .addr_b_o   (gen_b),
    .coef_addr_o(gen_coef)
  );

  // A slot is issued only in an unheld RUN cycle.
  assign issue     = (state_q == ST_RUN) && !hold;
  assign coef_addr = (state_q == ST_RUN) ? gen_coef : '0;
  assign addr_a_d  = issue ? gen_a : '0;
  assign addr_b_d  = issue ? gen_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      conj_q  <= 1'b0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (stage < STAGE_LIM) begin
              stage_q <= stage;
              conj_q  <= inverse;
              j_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!hold) begin
            j_q <= j_q + 1'b1;
            if (j_q == J_LAST) begin
              state_q <= (ROM_LAT == 1) ? ST_FLUSH : ST_DONE;
              dv_q    <= (ROM_LAT == 0);
            end
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
          dv_q    <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  if (ROM_LAT == 1) begin : g_lat1
    logic             we_q;
    logic [LOG2N-1:0] addr_a_q;
    logic [LOG2N-1:0] addr_b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        we_q     <= 1'b0;
        addr_a_q <= '0;
        addr_b_q <= '0;
      end else begin
        we_q     <= issue;
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
      end
    end

    assign o_we   = we_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
  end else begin : g_lat0
    assign o_we   = issue;
    assign addr_a = addr_a_d;
    assign addr_b = addr_b_d;
  end

  assign conj = conj_q;
  assign busy = busy_q;
  assign dv   = dv_q;
  assign err  = err_q;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench: stimulus queues expected butterfly slots and dv cycles,
// per-instance monitors pop and compare whenever o_we or dv is seen.
module tb_twiddle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int stage;
    int j;
    int coef;
    int a;
    int b;
    int cj;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   dvq16[$];
  int   dvq8[$];
  exp_t e16;
  exp_t e8;
  int   conj_exp8 = 0;

  // N=16, ROM_LAT=1 instance
  logic       rst16 = 1'b1, start16 = 1'b0, inv16 = 1'b0, hold16 = 1'b0;
  logic [2:0] stage16 = '0;
  logic [2:0] coef16;
  logic [3:0] a16, b16;
  logic       we16, conj16, busy16, dv16, err16;

  // N=8, ROM_LAT=0 instance
  logic       rst8 = 1'b1, start8 = 1'b0, inv8 = 1'b0, hold8 = 1'b0;
  logic [1:0] stage8 = '0;
  logic [1:0] coef8;
  logic [2:0] a8, b8;
  logic       we8, conj8, busy8, dv8, err8;

  twiddle_sequencer #(.N(16), .ROM_LAT(1)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .stage(stage16), .inverse(inv16),
    .hold(hold16), .coef_addr(coef16), .addr_a(a16), .addr_b(b16), .o_we(we16),
    .conj(conj16), .busy(busy16), .dv(dv16), .err(err16)
  );

  twiddle_sequencer #(.N(8), .ROM_LAT(0)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .stage(stage8), .inverse(inv8),
    .hold(hold8), .coef_addr(coef8), .addr_a(a8), .addr_b(b8), .o_we(we8),
    .conj(conj8), .busy(busy8), .dv(dv8), .err(err8)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference uses plain division/modulo on the textbook formula.
  function automatic exp_t model(input int n, input int s, input int j, input int cj);
    exp_t e;
    int half;
    half    = n >> (s + 1);
    e.stage = s;
    e.j     = j;
    e.coef  = (j << s) % (n / 2);
    e.a     = (j / half) * 2 * half + (j % half);
    e.b     = e.a + half;
    e.cj    = cj;
    return e;
  endfunction

  logic [2:0] coef16_prev = '0;

  always @(negedge clk) begin
    if (we16) begin
      if (q16.size() == 0) begin
        check("we16_unexpected", int'(we16), 0);
      end else begin
        e16 = q16.pop_front();
        check($sformatf("coef16 s%0d j%0d", e16.stage, e16.j), int'(coef16_prev), e16.coef);
        check($sformatf("addr_a16 s%0d j%0d", e16.stage, e16.j), int'(a16), e16.a);
        check($sformatf("addr_b16 s%0d j%0d", e16.stage, e16.j), int'(b16), e16.b);
        check($sformatf("conj16 s%0d j%0d", e16.stage, e16.j), int'(conj16), e16.cj);
        $display("slot16 stage=%0d j=%0d coef=%0d a=%0d b=%0d", e16.stage, e16.j, coef16_prev, a16, b16);
        if (e16.stage == 0 && e16.j == 3) begin
          check("vec s0j3 coef", int'(coef16_prev), 3);
          check("vec s0j3 a", int'(a16), 3);
          check("vec s0j3 b", int'(b16), 11);
        end
        if (e16.stage == 2 && e16.j == 3) begin
          check("vec s2j3 coef", int'(coef16_prev), 4);
          check("vec s2j3 a", int'(a16), 5);
          check("vec s2j3 b", int'(b16), 7);
        end
        if (e16.stage == 3 && e16.j == 5) begin
          check("vec s3j5 coef", int'(coef16_prev), 0);
          check("vec s3j5 a", int'(a16), 10);
          check("vec s3j5 b", int'(b16), 11);
        end
      end
    end
    if (dv16) begin
      if (dvq16.size() == 0) check("dv16_unexpected", int'(dv16), 0);
      else check("dv16_cycle", cyc, dvq16.pop_front());
    end
    coef16_prev = coef16;
  end

  always @(negedge clk) begin
    if (busy8) check("conj8_busy", int'(conj8), conj_exp8);
    if (we8) begin
      if (q8.size() == 0) begin
        check("we8_unexpected", int'(we8), 0);
      end else begin
        e8 = q8.pop_front();
        check($sformatf("coef8 s%0d j%0d", e8.stage, e8.j), int'(coef8), e8.coef);
        check($sformatf("addr_a8 s%0d j%0d", e8.stage, e8.j), int'(a8), e8.a);
        check($sformatf("addr_b8 s%0d j%0d", e8.stage, e8.j), int'(b8), e8.b);
        $display("slot8 stage=%0d j=%0d coef=%0d a=%0d b=%0d", e8.stage, e8.j, coef8, a8, b8);
      end
    end
    if (dv8) begin
      if (dvq8.size() == 0) check("dv8_unexpected", int'(dv8), 0);
      else check("dv8_cycle", cyc, dvq8.pop_front());
    end
  end

  task automatic chk_zero16(input string tag);
    check({tag, " coef"}, int'(coef16), 0);
    check({tag, " addr_a"}, int'(a16), 0);
    check({tag, " addr_b"}, int'(b16), 0);
    check({tag, " o_we"}, int'(we16), 0);
    check({tag, " conj"}, int'(conj16), 0);
    check({tag, " busy"}, int'(busy16), 0);
    check({tag, " dv"}, int'(dv16), 0);
    check({tag, " err"}, int'(err16), 0);
  endtask

  task automatic pass16(input int s, input int inv, input int hold_after, input int hold_len,
                        input bit busy_start, input bit done_start);
    int t;
    int guard;
    for (int j = 0; j < 8; j++) q16.push_back(model(16, s, j, inv));
    @(negedge clk); #1;
    start16 = 1'b1; stage16 = 3'(s); inv16 = inv[0];
    t = cyc;
    dvq16.push_back(t + 10 + hold_len);
    @(negedge clk); #1;
    start16 = 1'b0;
    check("busy16_after_start", int'(busy16), 1);
    check("conj16_latched", int'(conj16), inv);
    if (hold_len > 0) begin
      repeat (hold_after) @(negedge clk);
      #1 hold16 = 1'b1;
      repeat (hold_len) begin @(negedge clk); #1; end
      hold16 = 1'b0;
    end
    if (busy_start) begin
      start16 = 1'b1; stage16 = 3'd4;
      @(negedge clk); #1;
      start16 = 1'b0;
      check("err16_start_while_busy", int'(err16), 0);
      check("busy16_start_while_busy", int'(busy16), 1);
    end
    guard = 0;
    while (!dv16 && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!dv16) check("dv16_timeout", int'(dv16), 1);
    if (done_start) begin
      start16 = 1'b1; stage16 = 3'd0;
      @(negedge clk); #1;
      start16 = 1'b0;
      check("busy16_start_in_done", int'(busy16), 0);
      @(negedge clk); #1;
      check("busy16_start_in_done2", int'(busy16), 0);
    end else begin
      @(negedge clk); #1;
      check("busy16_end", int'(busy16), 0);
    end
    check("q16_drained", q16.size(), 0);
    check("dvq16_drained", dvq16.size(), 0);
    $display("pass16 stage=%0d inv=%0d hold=%0d start_cyc=%0d done", s, inv, hold_len, t);
  endtask

  task automatic pass8(input int s, input int inv);
    int t;
    int guard;
    for (int j = 0; j < 4; j++) q8.push_back(model(8, s, j, inv));
    @(negedge clk); #1;
    start8 = 1'b1; stage8 = 2'(s); inv8 = inv[0];
    conj_exp8 = inv;
    t = cyc;
    dvq8.push_back(t + 5);
    @(negedge clk); #1;
    start8 = 1'b0;
    check("busy8_after_start", int'(busy8), 1);
    guard = 0;
    while (!dv8 && guard < 30) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!dv8) check("dv8_timeout", int'(dv8), 1);
    @(negedge clk); #1;
    check("busy8_end", int'(busy8), 0);
    check("conj8_held_after_pass", int'(conj8), inv);
    check("q8_drained", q8.size(), 0);
    check("dvq8_drained", dvq8.size(), 0);
    $display("pass8 stage=%0d inv=%0d start_cyc=%0d done", s, inv, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero16("reset16");
    check("reset8 busy", int'(busy8), 0);
    check("reset8 conj", int'(conj8), 0);
    check("reset8 o_we", int'(we8), 0);
    check("reset8 addr_b", int'(b8), 0);
    #1 rst16 = 1'b0; rst8 = 1'b0;

    pass16(0, 0, 0, 0, 1'b0, 1'b0);
    pass16(2, 1, 0, 0, 1'b0, 1'b0);
    pass16(3, 0, 0, 0, 1'b0, 1'b0);
    pass16(1, 0, 2, 3, 1'b1, 1'b1);

    // Out-of-range stage is rejected with a single err pulse.
    @(negedge clk); #1;
    start16 = 1'b1; stage16 = 3'd4;
    @(negedge clk); #1;
    start16 = 1'b0;
    check("err16_bad_stage", int'(err16), 1);
    check("busy16_bad_stage", int'(busy16), 0);
    @(negedge clk); #1;
    check("err16_pulse_width", int'(err16), 0);
    check("busy16_bad_stage2", int'(busy16), 0);
    $display("bad stage request done");

    // Reset mid-pass at j=5, with start held during reset.
    for (int j = 0; j < 8; j++) q16.push_back(model(16, 0, j, 1));
    @(negedge clk); #1;
    start16 = 1'b1; stage16 = 3'd0; inv16 = 1'b1;
    dvq16.push_back(cyc + 10);
    @(negedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst16 = 1'b1; start16 = 1'b1;
    q16.delete();
    dvq16.delete();
    @(negedge clk); #1;
    rst16 = 1'b0; start16 = 1'b0;
    chk_zero16("mid_pass_reset");
    @(negedge clk); #1;
    check("busy16_start_with_rst", int'(busy16), 0);
    repeat (12) @(negedge clk);
    #1;
    $display("mid-pass reset done");
    pass16(0, 0, 0, 0, 1'b0, 1'b0);

    pass8(1, 1);
    pass8(2, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
